hex_ascii_tx: RTL and testbench
===============================

Name: hex_ascii_tx

Overview:
- Binary-to-ASCII hex character serializer; the transmit-side counterpart of the ASCII-to-hex input conversion.
- Accepts one NIBBLE_NUM-nibble data word over a valid/ready handshake.
- Emits one ASCII hex character per nibble, MSB nibble first, optionally followed by CR/LF.
- Output is a byte stream with valid/ready, feeding the UART Tx core for debug/telemetry output.

Parameters:
- NIBBLE_NUM, 4, number of hex characters per word; data width = NIBBLE_NUM*4; legal range 1..16.
- UPPER_CASE, 1, 1: A-F map to 0x41-0x46; 0: a-f map to 0x61-0x66.
- APPEND_CRLF, 1, 1: append 0x0D then 0x0A after the last nibble; 0: no terminator.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- iDATA  input  NIBBLE_NUM*4  word to print; sampled only on the input handshake.
- iVALID  input  1  iDATA valid.
- oREADY  output  1  block can accept a word.
- oCHAR  output  8  ASCII character.
- oCHAR_VALID  output  1  oCHAR valid.
- iCHAR_READY  input  1  downstream (UART Tx) accepts oCHAR.
- oBUSY  output  1  a word is being emitted.

Behaviour:
- Single clock CLK. Reset RST is synchronous, active-high.
- States: IDLE, SEND_HEX, SEND_CR, SEND_LF. State, shift register, char counter and oCHAR are all registered.
- Reset (RST high at an edge):
  - State -> IDLE.
  - oCHAR_VALID=0, oCHAR=0x00, oBUSY=0.
  - Shift register and counter cleared.
  - oREADY forced 0 while RST is high; iVALID ignored while RST is high.
- oREADY = (state==IDLE) && !RST. oBUSY = (state!=IDLE).
- Input accept: iVALID && oREADY at an edge.
  - iDATA is captured into the shift register.
  - State -> SEND_HEX. Nibble counter loaded with NIBBLE_NUM-1.
  - oCHAR_VALID=1 with the MSB-nibble character on the next cycle; latency 1 cycle.
- Character mapping:
  - 0-9 -> 0x30-0x39.
  - 10-15 -> 0x41-0x46 (UPPER_CASE=1) or 0x61-0x66 (UPPER_CASE=0).
- Output handshake: a character is consumed at an edge where oCHAR_VALID && iCHAR_READY.
  - While oCHAR_VALID=1 and iCHAR_READY=0, oCHAR is held stable and oCHAR_VALID stays 1.
  - No drop, no duplication.
  - oCHAR_VALID never deasserts without a handshake, except on reset.
- SEND_HEX: on each consume, shift left by 4 and decrement the counter. On consuming the last nibble (counter==0):
  - APPEND_CRLF=1: -> SEND_CR, oCHAR=0x0D.
  - APPEND_CRLF=0: -> IDLE, oCHAR_VALID=0.
- SEND_CR: on consume -> SEND_LF, oCHAR=0x0A.
- SEND_LF: on consume -> IDLE, oCHAR_VALID=0.
- Throughput:
  - With iCHAR_READY tied 1, characters appear on consecutive cycles: NIBBLE_NUM (+2 if CRLF) cycles per word.
  - IDLE is entered the cycle after the final consume; the next word can be accepted at that edge.
  - Minimum gap between words: 1 cycle with oCHAR_VALID=0.
- iVALID/iDATA while busy: ignored; no capture, no effect on the in-flight word.
- iDATA changes in the same cycle as the accept: the value present at the accept edge is used.
- Reset mid-word: at the edge, output is aborted and oCHAR_VALID drops. Remaining nibbles and CR/LF are not emitted, and there is no partial resume.
- Counter width: $clog2(NIBBLE_NUM) minimum 1 bit. Counter wraps only via reload on accept; never decrements below 0.

Test Plan:
- Defaults, iDATA=0x1A2F accepted, iCHAR_READY=1 -> oCHAR 0x31,0x41,0x32,0x46,0x0D,0x0A on 6 consecutive cycles starting 1 cycle after accept; oREADY=0 and oBUSY=1 throughout; oREADY=1 the cycle after 0x0A is consumed.
- Backpressure: word 0x1A2F, iCHAR_READY=0 for 3 cycles while oCHAR=0x41 -> 0x41 held valid and stable for 4 cycles, then sequence continues 0x32,0x46,0x0D,0x0A; exactly 6 handshakes total.
- UPPER_CASE=0, APPEND_CRLF=0, iDATA=0xBEEF -> 0x62,0x65,0x65,0x66, then oCHAR_VALID=0 and oREADY=1 on the next cycle.
- APPEND_CRLF=0, iDATA=0x0009, then iVALID held high with 0x1234 -> first word 0x30,0x30,0x30,0x39; 0x1234 accepted only after return to IDLE and emitted 0x31,0x32,0x33,0x34.
- During the busy period, iVALID pulsed with 0xFFFF -> ignored; output is only the original word's characters.
- Reset mid-word (RST high 1 cycle after 2 characters of 0x1A2F) -> oCHAR_VALID=0 at that edge, no 0x32/0x46/CR/LF; after release oREADY=1; new word 0xC0DE -> 0x43,0x30,0x44,0x45,0x0D,0x0A.

Source files
------------

// File: rtl/hex_ascii_tx.sv
// hex_ascii_tx
// Takes one NIBBLE_NUM-nibble word over a valid/ready handshake and turns it
// into ASCII hex characters, most significant nibble first. CR/LF can
// optionally follow the last nibble. The characters leave as a byte stream
// with valid/ready, intended to feed a UART transmitter.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   iDATA        word to print, sampled only on the input handshake
//   iVALID       iDATA valid
//   oREADY       block can accept a word (IDLE and not in reset)
//   oCHAR        ASCII character (registered)
//   oCHAR_VALID  oCHAR valid
//   iCHAR_READY  downstream accepts oCHAR
//   oBUSY        a word is being emitted
//
// state      | meaning
// S_IDLE     | waiting for a word, oREADY high
// S_SEND_HEX | presenting hex characters, one per nibble
// S_SEND_CR  | presenting 0x0D
// S_SEND_LF  | presenting 0x0A
module hex_ascii_tx #(
    parameter int NIBBLE_NUM  = 4,
    parameter int UPPER_CASE  = 1,
    parameter int APPEND_CRLF = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NIBBLE_NUM*4-1:0] iDATA,
    input  logic                    iVALID,
    output logic                    oREADY,
    output logic [7:0]              oCHAR,
    output logic                    oCHAR_VALID,
    input  logic                    iCHAR_READY,
    output logic                    oBUSY
);

    localparam int W  = NIBBLE_NUM * 4;
    localparam int CW = (NIBBLE_NUM > 1) ? $clog2(NIBBLE_NUM) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND_HEX = 2'd1,
        S_SEND_CR  = 2'd2,
        S_SEND_LF  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_shift, w_shift_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;
    logic [7:0]      r_char,  w_char_nxt;
    logic [W-1:0]    w_shift_adv;
    logic            w_accept;

    function automatic logic [7:0] f_hex2ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else if (UPPER_CASE != 0)
            return 8'h37 + {4'h0, nib};   // 0x37 + 10 = 'A'
        else
            return 8'h57 + {4'h0, nib};   // 0x57 + 10 = 'a'
    endfunction

    assign oREADY      = (r_state == S_IDLE) && !RST;
    assign oBUSY       = (r_state != S_IDLE);
    // Every non-IDLE state presents a character, so valid follows the state.
    assign oCHAR_VALID = (r_state != S_IDLE);
    assign oCHAR       = r_char;

    assign w_accept    = iVALID && oREADY;
    assign w_shift_adv = r_shift << 4;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_char_nxt  = r_char;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SEND_HEX;
                    w_shift_nxt = iDATA;
                    w_cnt_nxt   = CW'(NIBBLE_NUM - 1);
                    w_char_nxt  = f_hex2ascii(iDATA[W-1 -: 4]);
                end
            end
            S_SEND_HEX: begin
                if (iCHAR_READY) begin
                    if (r_cnt == '0) begin
                        if (APPEND_CRLF != 0) begin
                            w_state_nxt = S_SEND_CR;
                            w_char_nxt  = 8'h0D;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_char_nxt  = 8'h00;
                        end
                    end else begin
                        w_shift_nxt = w_shift_adv;
                        w_cnt_nxt   = r_cnt - CW'(1);
                        w_char_nxt  = f_hex2ascii(w_shift_adv[W-1 -: 4]);
                    end
                end
            end
            S_SEND_CR: begin
                if (iCHAR_READY) begin
                    w_state_nxt = S_SEND_LF;
                    w_char_nxt  = 8'h0A;
                end
            end
            S_SEND_LF: begin
                if (iCHAR_READY) begin
                    w_state_nxt = S_IDLE;
                    w_char_nxt  = 8'h00;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_char_nxt  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_char  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_char  <= w_char_nxt;
        end
    end

endmodule

// File: tb/tb_hex_ascii_tx.sv
// Directed bench for hex_ascii_tx. Two instances share stimulus:
//   dut_a: defaults (upper case, CR/LF appended)
//   dut_b: lower case, no CR/LF
module tb_hex_ascii_tx;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [15:0]     iDATA = '0;
    logic            iVALID = 1'b0;
    logic            iCHAR_READY = 1'b1;

    logic [1:0]      rdy, cv, bsy;
    logic [1:0][7:0] ch;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_a    = 0;
    int hs_base = 0;
    logic [7:0] exp_b [8];

    always #5 CLK = ~CLK;

    hex_ascii_tx #(.NIBBLE_NUM(4), .UPPER_CASE(1), .APPEND_CRLF(1)) dut_a (
        .CLK(CLK), .RST(RST), .iDATA(iDATA), .iVALID(iVALID),
        .oREADY(rdy[0]), .oCHAR(ch[0]), .oCHAR_VALID(cv[0]),
        .iCHAR_READY(iCHAR_READY), .oBUSY(bsy[0])
    );

    hex_ascii_tx #(.NIBBLE_NUM(4), .UPPER_CASE(0), .APPEND_CRLF(0)) dut_b (
        .CLK(CLK), .RST(RST), .iDATA(iDATA), .iVALID(iVALID),
        .oREADY(rdy[1]), .oCHAR(ch[1]), .oCHAR_VALID(cv[1]),
        .iCHAR_READY(iCHAR_READY), .oBUSY(bsy[1])
    );

    // Count output handshakes on dut_a.
    always @(posedge CLK) begin
        if (!RST && cv[0] && iCHAR_READY) hs_a <= hs_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_exp(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) exp_b[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic do_reset();
        RST = 1'b1; iVALID = 1'b0; iCHAR_READY = 1'b1;
        step(); step();
        chk("rst_ready_a", 32'(rdy[0]), 0);
        chk("rst_valid_a", 32'(cv[0]), 0);
        chk("rst_char_a",  32'(ch[0]), 0);
        chk("rst_busy_a",  32'(bsy[0]), 0);
        chk("rst_valid_b", 32'(cv[1]), 0);
        RST = 1'b0;
        #1;
        chk("rel_ready_a", 32'(rdy[0]), 1);
        chk("rel_ready_b", 32'(rdy[1]), 1);
    endtask

    task automatic accept(input logic [15:0] d);
        iDATA = d; iVALID = 1'b1;
        step();
        iVALID = 1'b0;
    endtask

    // Checks n characters from exp_b starting at index 'from', consuming each.
    task automatic expect_stream(input int sel, input int from, input int n, input string tag);
        for (int i = from; i < from + n; i++) begin
            chk($sformatf("%s_char%0d", tag, i), 32'(ch[sel]), 32'(exp_b[i]));
            chk($sformatf("%s_valid%0d", tag, i), 32'(cv[sel]), 1);
            chk($sformatf("%s_ready%0d", tag, i), 32'(rdy[sel]), 0);
            chk($sformatf("%s_busy%0d", tag, i), 32'(bsy[sel]), 1);
            step();
        end
    endtask

    task automatic expect_idle(input int sel, input string tag);
        chk({tag, "_end_valid"}, 32'(cv[sel]), 0);
        chk({tag, "_end_ready"}, 32'(rdy[sel]), 1);
        chk({tag, "_end_busy"},  32'(bsy[sel]), 0);
    endtask

    initial begin
        // 1: basic word, defaults, no backpressure
        do_reset();
        hs_base = hs_a;
        accept(16'h1A2F);
        load_exp(64'h3141_3246_0D0A, 6);
        expect_stream(0, 0, 6, "basic");
        expect_idle(0, "basic");
        chk("basic_hs", 32'(hs_a - hs_base), 6);

        // 2: backpressure on 'A'
        do_reset();
        hs_base = hs_a;
        accept(16'h1A2F);
        expect_stream(0, 0, 1, "bp");
        for (int k = 0; k < 4; k++) begin
            iCHAR_READY = (k == 3);
            chk($sformatf("bp_hold_char%0d", k), 32'(ch[0]), 32'h41);
            chk($sformatf("bp_hold_valid%0d", k), 32'(cv[0]), 1);
            step();
        end
        iCHAR_READY = 1'b1;
        expect_stream(0, 2, 4, "bp");
        expect_idle(0, "bp");
        chk("bp_hs", 32'(hs_a - hs_base), 6);

        // 3: lower case, no CR/LF
        do_reset();
        accept(16'hBEEF);
        load_exp(64'h6265_6566, 4);
        expect_stream(1, 0, 4, "lc");
        expect_idle(1, "lc");

        // 4: back-to-back words with iVALID held high
        do_reset();
        iDATA = 16'h0009; iVALID = 1'b1;
        step();
        iDATA = 16'h1234;
        load_exp(64'h3030_3039, 4);
        expect_stream(1, 0, 4, "b2b1");
        expect_idle(1, "b2b_gap");
        step();
        iVALID = 1'b0;
        load_exp(64'h3132_3334, 4);
        expect_stream(1, 0, 4, "b2b2");
        expect_idle(1, "b2b2");

        // 5: iVALID pulsed with 0xFFFF while busy is ignored
        do_reset();
        hs_base = hs_a;
        accept(16'h1A2F);
        load_exp(64'h3141_3246_0D0A, 6);
        expect_stream(0, 0, 1, "ign");
        iDATA = 16'hFFFF; iVALID = 1'b1;
        expect_stream(0, 1, 2, "ign");
        iVALID = 1'b0;
        expect_stream(0, 3, 3, "ign");
        expect_idle(0, "ign");
        chk("ign_hs", 32'(hs_a - hs_base), 6);

        // 6: reset mid-word, then a fresh word
        do_reset();
        hs_base = hs_a;
        accept(16'h1A2F);
        expect_stream(0, 0, 2, "mid");
        chk("mid_pre_char", 32'(ch[0]), 32'h32);
        RST = 1'b1;
        step();
        chk("mid_rst_valid", 32'(cv[0]), 0);
        chk("mid_rst_ready", 32'(rdy[0]), 0);
        chk("mid_rst_char",  32'(ch[0]), 0);
        RST = 1'b0;
        #1;
        chk("mid_rel_ready", 32'(rdy[0]), 1);
        step();
        chk("mid_no_resume", 32'(cv[0]), 0);
        chk("mid_hs", 32'(hs_a - hs_base), 2);
        accept(16'hC0DE);
        load_exp(64'h4330_4445_0D0A, 6);
        expect_stream(0, 0, 6, "new");
        expect_idle(0, "new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
